// File: rtl/mux_nw_arb_pkg.sv
// Shared constants for the NCH-way registered mux/arbiter and its users.
package mux_nw_arb_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   XFER_CNT_W  = 8;
endpackage

// File: rtl/mux_nw_arb_if.sv
// Handshake bundle between channel sources, the mux/arbiter and its consumer.
interface mux_nw_arb_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nw_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NCH]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'((int'(ptr) + k) % NCH);
      end
    end
  end
endmodule

// File: rtl/mux_nw_arb.sv
// NCH-way registered mux with manual or round-robin selection behind valid/ready.
// Optional saturating transfer counter enabled by MUX_NW_ARB_XFER_CNT_EN.
module mux_nw_arb
  import mux_nw_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MUX_NW_ARB_XFER_CNT_EN
  output logic [XFER_CNT_W-1:0] xfer_cnt,
`endif
  mux_nw_arb_if.slave           bus
);
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;
  logic             vld_p1;
  logic [SELW-1:0]  ptr_p1;

  logic             rr_valid;
  logic [SELW-1:0]  rr_idx;
  logic             man_valid;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt;
  logic             load_en;
  logic             xfer_in;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req       (bus.in_valid),
    .ptr       (ptr_p1),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // An out-of-range manual select never indexes in_valid.
  assign man_valid = (32'(bus.sel) < NCH) && bus.in_valid[bus.sel];

  assign gnt_valid = (bus.mode == MODE_RR) ? rr_valid : man_valid;
  assign gnt       = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;
  assign load_en   = !vld_p1 || bus.out_ready;
  assign xfer_in   = load_en && gnt_valid && !rst;

  assign bus.in_ready  = xfer_in ? (NCH'(1) << gnt) : '0;
  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.out_valid = vld_p1;

  function automatic logic [SELW-1:0] ptr_next(input logic [SELW-1:0] g);
    return (g == SELW'(NCH - 1)) ? '0 : g + SELW'(1);
  endfunction

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      ch_p1   <= '0;
      vld_p1  <= 1'b0;
      ptr_p1  <= '0;
    end else begin
      if (xfer_in) begin
        data_p1 <= bus.in_data[gnt*WIDTH +: WIDTH];
        ch_p1   <= gnt;
        vld_p1  <= 1'b1;
        if (bus.mode == MODE_RR) ptr_p1 <= ptr_next(gnt);
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

`ifdef MUX_NW_ARB_XFER_CNT_EN
  function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] c);
    return (&c) ? c : c + XFER_CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)          xfer_cnt <= '0;
    else if (xfer_in) xfer_cnt <= sat_inc(xfer_cnt);
  end
`endif
endmodule

// File: tb/tb_mux_nw_arb.sv
// Directed self-checking bench for mux_nw_arb (NCH=4, WIDTH=4).
`timescale 1ns/1ps
module tb_mux_nw_arb;
  import mux_nw_arb_pkg::*;

  localparam int WIDTH = 4;
  localparam int NCH   = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
`ifdef MUX_NW_ARB_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt;
`endif

  always #5 clk = ~clk;

  mux_nw_arb_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  mux_nw_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MUX_NW_ARB_XFER_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .bus      (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_data   = 16'h8421;
    bus.in_valid  = 4'b1111;
    bus.mode      = MODE_MANUAL;
    bus.sel       = '0;
    bus.out_ready = 1'b1;

    // Reset state; in_ready must stay low despite all channels valid.
    tick(); tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
    check_eq("rst_out_ch", 32'(bus.out_ch), 32'h0);
`ifdef MUX_NW_ARB_XFER_CNT_EN
    check_eq("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
    rst = 1'b0;

    // Manual sweep over one-hot channel data.
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      check_eq("man_in_ready", 32'(bus.in_ready), 32'(1 << s));
      tick();
      check_eq("man_out_data", 32'(bus.out_data), 32'(1 << s));
      check_eq("man_out_ch", 32'(bus.out_ch), 32'(s));
      check_eq("man_out_valid", 32'(bus.out_valid), 32'h1);
    end

    // Round-robin fairness from ptr=0 (manual transfers left it there).
    bus.mode = MODE_RR;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("rr_out_ch", 32'(bus.out_ch), 32'(i % 4));
      check_eq("rr_out_data", 32'(bus.out_data), 32'(1 << (i % 4)));
      check_eq("rr_out_valid", 32'(bus.out_valid), 32'h1);
    end

    // Move ptr to 1 with a single grant to channel 0, then skip and wrap.
    bus.in_valid = 4'b0001;
    tick();
    check_eq("rr_pre_ch", 32'(bus.out_ch), 32'h0);
    bus.in_valid = 4'b1001;
    tick();
    check_eq("rr_skip_ch0", 32'(bus.out_ch), 32'h3);
    check_eq("rr_skip_data0", 32'(bus.out_data), 32'h8);
    tick();
    check_eq("rr_wrap_ch1", 32'(bus.out_ch), 32'h0);
    tick();
    check_eq("rr_skip_ch2", 32'(bus.out_ch), 32'h3);

    // Backpressure: load channel 2 then stall for three cycles.
    bus.mode     = MODE_MANUAL;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1111;
    tick();
    check_eq("bp_load_data", 32'(bus.out_data), 32'h4);
    bus.out_ready = 1'b0;
    bus.sel       = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check_eq("bp_hold_data", 32'(bus.out_data), 32'h4);
      check_eq("bp_hold_ch", 32'(bus.out_ch), 32'h2);
      check_eq("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 32'h2);
    tick();
    check_eq("bp_reload_data", 32'(bus.out_data), 32'h2);
    check_eq("bp_reload_ch", 32'(bus.out_ch), 32'h1);
    check_eq("bp_reload_valid", 32'(bus.out_valid), 32'h1);

    // Manual select of an invalid channel: pending word drains, nothing reloads.
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    check_eq("inv_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_eq("inv_out_valid", 32'(bus.out_valid), 32'h0);
    #1;
    check_eq("inv_in_ready_idle", 32'(bus.in_ready), 32'h0);

    // Reach ptr=2 with out_valid=1 (grant channel 1 from ptr 0), then reset.
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b0010;
    tick();
    check_eq("pre_rst_ch", 32'(bus.out_ch), 32'h1);
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 4'b1111;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("mid_rst_data", 32'(bus.out_data), 32'h0);
    check_eq("mid_rst_ch", 32'(bus.out_ch), 32'h0);
`ifdef MUX_NW_ARB_XFER_CNT_EN
    check_eq("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
    #1;
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check_eq("post_rst_ch", 32'(bus.out_ch), 32'h0);
    check_eq("post_rst_data", 32'(bus.out_data), 32'h1);
    tick();
    check_eq("post_rst_ch_next", 32'(bus.out_ch), 32'h1);

`ifdef MUX_NW_ARB_XFER_CNT_EN
    check_eq("cnt_two", 32'(xfer_cnt), 32'h2);
    for (int i = 0; i < 298; i++) tick();
    check_eq("cnt_sat", 32'(xfer_cnt), 32'hff);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_nw_arb.md
Name: mux_nw_arb

Overview:
- Parametrised successor to the team's fixed 4:1 4-bit combinational mux.
- Selects one of NCH channels, each WIDTH bits wide, and registers the result behind a valid/ready handshake.
- Two selection modes:
  - manual: an explicit select drives the choice.
  - round-robin: the block picks the next valid channel in fair rotation.
- Sits between operand/result sources and a single consumer, e.g. the register-file write port or ALU operand latch in the CPU datapath.

Parameters:
- WIDTH, 4, data bits per channel.
- NCH, 4, number of input channels; legal range 2..16.
- SELW, $clog2(NCH), select/channel-index width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; at most one bit high per cycle.
- mode  in  1  selection mode: 0 = manual, 1 = round-robin.
- sel  in  SELW  manual channel select; ignored when mode=1.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SELW  index of the channel that produced out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset (synchronous, sampled on clk while rst=1):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is all zeros during reset.
- Output register is single-entry. load_en = !out_valid || out_ready.
- Grant logic, combinational, evaluated every cycle:
  - Manual mode: grant channel = sel when sel<NCH and in_valid[sel]=1; otherwise no grant.
  - Round-robin mode: grant the first i with in_valid[i]=1, scanning ptr, ptr+1, … NCH-1, 0, … ptr-1 (modulo NCH). No valid channel means no grant.
- in_ready[g] = load_en && grant exists, where g is the granted channel; all other bits are 0.
- Transfer in:
  - Occurs on the edge where in_valid[g] && in_ready[g].
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
- Transfer out:
  - Occurs on the edge where out_valid && out_ready.
  - If no simultaneous transfer in, out_valid <= 0.
  - Simultaneous in and out in the same cycle: the register reloads and out_valid stays 1, giving full throughput of 1 word/cycle.
- Latency: 1 cycle from an input transfer to out_valid.
- Pointer update:
  - Only on a transfer in while mode=1: ptr <= (g+1) mod NCH, wrapping NCH-1 -> 0.
  - Manual transfers leave ptr unchanged.
- Stall: out_valid=1 and out_ready=0:
  - load_en=0 and all in_ready are 0.
  - out_data and out_ch are held stable.
- Mode or sel change: takes effect combinationally in the same cycle. The registered output is unaffected; ptr is preserved across mode changes.
- Out-of-range sel (sel>=NCH, only possible when NCH is not a power of 2): no grant, no transfer.
- Reset mid-operation: in-flight output data is discarded; all outputs return to reset values on the next edge.
- Datapath performs no arithmetic. All widths are exact; no truncation or extension.

Optional Feature:
- Macro: MUX_NW_ARB_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, 8 bits: a saturating count of input transfers since reset.
  - Increments by 1 on each transfer in and saturates at 255.
  - Reset value 0.
- Undefined:
  - Port and counter are absent; interface and behaviour are otherwise identical.

Decomposition:
- Shared package mux_nw_arb_pkg holds:
  - mode encodings MODE_MANUAL=1'b0 and MODE_RR=1'b1;
  - the counter width constant XFER_CNT_W=8.
- One natural sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_valid, gnt_idx[SELW].
  - Reusable by future bus arbiters.
- Top level holds the output register, the ptr register, and the manual/round-robin grant mux.

Test Plan:
- Manual sweep:
  - Setup: NCH=4, WIDTH=4, one-hot data A..D = 0001/0010/0100/1000, all valid, out_ready=1, mode=0.
  - Stimulus: sel = 0,1,2,3.
  - Required response: out_data 0001, 0010, 0100, 1000 one cycle after each sel, with out_ch matching sel.
- Round-robin fairness:
  - Stimulus: all valid, mode=1, out_ready=1 for 8 cycles.
  - Required response: out_ch sequence 0,1,2,3,0,1,2,3; out_valid stays 1 continuously after the first cycle.
- Round-robin skip and wrap:
  - Stimulus: in_valid=4'b1001, ptr=1.
  - Required response: grant goes to 3, then 0, then 3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a load of 0100.
  - Required response: out_data=0100 held, in_ready=0 throughout. Releasing out_ready gives one transfer out, with a simultaneous reload when a channel is valid.
- Manual with invalid channel:
  - Stimulus: sel=2, in_valid[2]=0.
  - Required response: in_ready=0 and out_valid drops to 0 after the pending data drains.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle while out_valid=1 and ptr=2.
  - Required response: out_valid=0, out_data=0, out_ch=0; the next round-robin grant starts at channel 0. With MUX_NW_ARB_XFER_CNT_EN defined, xfer_cnt=0 after reset and saturates at 255 after 300 transfers.
